// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared key FSM state type and default timing constants
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      KEY_IDLE,
      KEY_PRESS_DEB,
      KEY_HELD,
      KEY_RELEASE_DEB
   } key_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES      = 500000;
   localparam int DEFAULT_REPEAT_DELAY_CYCLES  = 25000000;
   localparam int DEFAULT_REPEAT_PERIOD_CYCLES = 5000000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int count_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/input_conditioner_synchronizer.sv
// rtl/input_conditioner_synchronizer.sv - two-flop synchronizer with async reset to a chosen value
module input_conditioner_synchronizer #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - reset/switch synchronization and debounced key step pulse
// Optional auto-repeat while held: INPUT_CONDITIONER_AUTO_REPEAT_EN
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_n,
   input  logic switch_in,
   output logic reset_s2_n,
   output logic key_pressed,
   output logic manual_clock_enabled
);

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
   localparam bit AUTO_REPEAT = 1'b1;
`else
   localparam bit AUTO_REPEAT = 1'b0;
`endif

   // One counter serves debounce and, when enabled, repeat timing in HELD.
   localparam int CNT_RANGE = AUTO_REPEAT
      ? max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)
      : DEBOUNCE_CYCLES;
   localparam int CNT_W = count_width(CNT_RANGE);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
   localparam cnt_t CNT_MAX  = '1;

   logic       key_n_s;
   logic       key_down;
   key_state_t state;
   cnt_t       cnt;

   input_conditioner_synchronizer #(.RESET_VALUE(1'b0)) u_reset_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (1'b1),
      .q       (reset_s2_n)
   );

   input_conditioner_synchronizer #(.RESET_VALUE(1'b1)) u_key_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (key_n),
      .q       (key_n_s)
   );

   input_conditioner_synchronizer #(.RESET_VALUE(1'b0)) u_switch_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (switch_in),
      .q       (manual_clock_enabled)
   );

   assign key_down = ~key_n_s;

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
   localparam cnt_t REP_DELAY_LAST  = cnt_t'(REPEAT_DELAY_CYCLES - 1);
   localparam cnt_t REP_PERIOD_LAST = cnt_t'(REPEAT_PERIOD_CYCLES - 1);

   // Repeat only after a real accepted press, never after a press held through reset.
   logic rep_armed;
   logic rep_started;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= KEY_HELD;
         cnt         <= '0;
         key_pressed <= 1'b0;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
         rep_armed   <= 1'b0;
         rep_started <= 1'b0;
`endif
      end else begin
         key_pressed <= 1'b0;
         unique case (state)
            KEY_IDLE: begin
               if (key_down) begin
                  state <= KEY_PRESS_DEB;
                  cnt   <= '0;
               end
            end
            KEY_PRESS_DEB: begin
               if (!key_down) begin
                  state <= KEY_IDLE;
               end else if (cnt == DEB_LAST) begin
                  state       <= KEY_HELD;
                  cnt         <= '0;
                  key_pressed <= 1'b1;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
                  rep_armed   <= 1'b1;
                  rep_started <= 1'b0;
`endif
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            KEY_HELD: begin
               if (!key_down) begin
                  state <= KEY_RELEASE_DEB;
                  cnt   <= '0;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
                  rep_armed <= 1'b0;
               end else if (rep_armed) begin
                  if (cnt == (rep_started ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
                     key_pressed <= 1'b1;
                     rep_started <= 1'b1;
                     cnt         <= '0;
                  end else if (cnt != CNT_MAX) begin
                     cnt <= cnt + 1'b1;
                  end
`endif
               end
            end
            KEY_RELEASE_DEB: begin
               if (key_down) begin
                  state <= KEY_HELD;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state <= KEY_IDLE;
                  cnt   <= '0;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= KEY_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner (INPUT_CONDITIONER_AUTO_REPEAT_EN aware)
module tb_input_conditioner;
   import input_conditioner_pkg::*;

   localparam int DEB  = 8;
   localparam int RDLY = 40;
   localparam int RPER = 16;
   localparam int LAT  = DEB + 3;

   logic clock     = 1'b0;
   logic reset_n   = 1'b0;
   logic key_n     = 1'b1;
   logic switch_in = 1'b0;
   logic reset_s2_n;
   logic key_pressed;
   logic manual_clock_enabled;

   int errors    = 0;
   int checks    = 0;
   int cyc       = 0;
   int pulse_cnt = 0;
   int exp_cyc;
   int exp_q[$];

   input_conditioner #(
      .DEBOUNCE_CYCLES      (DEB),
      .REPEAT_DELAY_CYCLES  (RDLY),
      .REPEAT_PERIOD_CYCLES (RPER)
   ) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .key_n                (key_n),
      .switch_in            (switch_in),
      .reset_s2_n           (reset_s2_n),
      .key_pressed          (key_pressed),
      .manual_clock_enabled (manual_clock_enabled)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Every pulse must match the oldest pending expectation within one clock.
   always @(negedge clock) begin
      if (key_pressed === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_pulse: key_pressed=1 at cycle %0d, required 0", cyc);
         end else begin
            exp_cyc = exp_q.pop_front();
            if (cyc < exp_cyc - 1 || cyc > exp_cyc + 1) begin
               errors = errors + 1;
               $display("FAIL pulse_time: pulse at cycle %0d, required %0d +/-1", cyc, exp_cyc);
            end
         end
      end
   end

   task automatic check_idle(input string name);
      checks = checks + 1;
      if (dut.state !== KEY_IDLE) begin
         errors = errors + 1;
         $display("FAIL %s: state=%0d, required %0d", name, dut.state, KEY_IDLE);
      end
   endtask

   task automatic check_drained(input string name, input int p0, input int n);
      checks = checks + 1;
      if (exp_q.size() != 0 || pulse_cnt != p0 + n) begin
         errors = errors + 1;
         $display("FAIL %s: pulses=%0d pending=%0d, required pulses=%0d pending=0",
                  name, pulse_cnt - p0, exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      key_n = 1'b1;
      switch_in = 1'b0;
      repeat (3) begin
         @(negedge clock);
         checks = checks + 1;
         if ({reset_s2_n, key_pressed, manual_clock_enabled} !== 3'b000) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: got %b, required 000",
                     {reset_s2_n, key_pressed, manual_clock_enabled});
         end
      end
      reset_n = 1'b1;
      @(negedge clock);
      checks = checks + 1;
      if (reset_s2_n !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL reset_edge1: reset_s2_n=%b, required 0", reset_s2_n);
      end
      @(negedge clock);
      checks = checks + 1;
      if (reset_s2_n !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL reset_edge2: reset_s2_n=%b, required 1", reset_s2_n);
      end
      repeat (20) @(negedge clock);
      check_idle("idle_after_reset");
   endtask

   task automatic test_clean_press();
      int p0;
      int n;
      p0 = pulse_cnt;
      n = 1;
      @(negedge clock);
      key_n = 1'b0;
      exp_q.push_back(cyc + LAT);
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
      exp_q.push_back(cyc + LAT + RDLY);
      n = 2;
`endif
      repeat (50) @(negedge clock);
      key_n = 1'b1;
      repeat (2 * DEB + 6) @(negedge clock);
      check_drained("clean_press", p0, n);
      check_idle("idle_after_press");
   endtask

   task automatic test_bounce();
      int p0;
      p0 = pulse_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         key_n = 1'b0;
         repeat (2) @(negedge clock);
         key_n = 1'b1;
         repeat (3) @(negedge clock);
      end
      repeat (20) @(negedge clock);
      check_drained("bounce", p0, 0);
      check_idle("idle_after_bounce");
   endtask

   task automatic test_held_through_reset();
      int p0;
      p0 = pulse_cnt;
      @(negedge clock);
      key_n = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (30) @(negedge clock);
      check_drained("held_through_reset", p0, 0);
      key_n = 1'b1;
      repeat (20) @(negedge clock);
      key_n = 1'b0;
      exp_q.push_back(cyc + LAT);
      repeat (20) @(negedge clock);
      key_n = 1'b1;
      repeat (2 * DEB + 6) @(negedge clock);
      check_drained("repress_after_reset", p0, 1);
   endtask

   task automatic test_reset_mid_debounce();
      int p0;
      p0 = pulse_cnt;
      @(negedge clock);
      key_n = 1'b0;
      repeat (6) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks = checks + 1;
      if (reset_s2_n !== 1'b0 || dut.state !== KEY_HELD) begin
         errors = errors + 1;
         $display("FAIL async_abort: reset_s2_n=%b state=%0d, required 0 and %0d",
                  reset_s2_n, dut.state, KEY_HELD);
      end
      @(negedge clock);
      key_n = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (25) @(negedge clock);
      check_drained("abort_no_pulse", p0, 0);
      check_idle("idle_after_abort");
   endtask

   task automatic test_switch();
      int highs;
      @(negedge clock);
      switch_in = 1'b1;
      @(negedge clock);
      checks = checks + 1;
      if (manual_clock_enabled !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL switch_edge1: manual_clock_enabled=%b, required 0", manual_clock_enabled);
      end
      @(negedge clock);
      checks = checks + 1;
      if (manual_clock_enabled !== 1'b1) begin
         errors = errors + 1;
         $display("FAIL switch_edge2: manual_clock_enabled=%b, required 1", manual_clock_enabled);
      end
      switch_in = 1'b0;
      repeat (5) @(negedge clock);
      #2 switch_in = 1'b1;
      #10 switch_in = 1'b0;
      highs = 0;
      repeat (8) begin
         @(negedge clock);
         if (manual_clock_enabled === 1'b1) highs++;
      end
      checks = checks + 1;
      if (highs > 1 || manual_clock_enabled !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL switch_glitch: high clocks=%0d final=%b, required <=1 and 0",
                  highs, manual_clock_enabled);
      end
   endtask

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
   task automatic test_auto_repeat();
      int p0;
      int c;
      p0 = pulse_cnt;
      @(negedge clock);
      key_n = 1'b0;
      c = cyc + LAT;
      exp_q.push_back(c);
      for (int k = 0; k < 4; k++) exp_q.push_back(c + RDLY + k * RPER);
      repeat (100) @(negedge clock);
      key_n = 1'b1;
      repeat (30) @(negedge clock);
      check_drained("auto_repeat", p0, 5);
   endtask
`endif

   initial begin
      #200000;
      errors = errors + 1;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_held_through_reset();
      test_reset_mid_debounce();
      test_switch();
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
      test_auto_repeat();
`endif
      repeat (5) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
